// File: rtl/button_event_classifier.sv
// Classifies debounced press/release strobes into click, double-click, long-press
// and auto-repeat pulses. The repeat pulse port is auto_repeat because "repeat" is a reserved word.
module button_event_classifier #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int DCLICK_TICKS = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_down,
  input  logic btn_up,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic auto_repeat,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG,
    WAIT2,
    PRESSED2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'((DCLICK_TICKS > 0) ? DCLICK_TICKS - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             click_nxt, dbl_nxt, long_nxt, rpt_nxt, held_nxt;
  logic             dn, up;
  logic             long_exp, rpt_exp, dclick_exp;

  // Coincident press and release strobes cancel each other out.
  assign dn = btn_down & ~btn_up;
  assign up = btn_up & ~btn_down;

  assign long_exp   = tick && (cnt == LONG_LAST);
  assign rpt_exp    = tick && (cnt == REPEAT_LAST);
  assign dclick_exp = tick && (cnt == DCLICK_LAST) && (DCLICK_TICKS != 0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? cnt + CNT_W'(1) : cnt;
    click_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
    rpt_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (dn) state_nxt = PRESSED;
      end
      PRESSED: begin
        // A button edge takes priority over a timer expiring in the same cycle.
        if (up) begin
          if (DCLICK_TICKS == 0) begin
            click_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT2;
          end
        end else if (long_exp) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end
      end
      LONG: begin
        if (up) begin
          state_nxt = IDLE;
        end else if (rpt_exp) begin
          rpt_nxt = 1'b1;
          cnt_nxt = '0;
        end
      end
      WAIT2: begin
        if (dn) begin
          state_nxt = PRESSED2;
        end else if (dclick_exp) begin
          click_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRESSED2: begin
        if (up) begin
          dbl_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (long_exp) begin
          // The first click is still owed when the second press turns long.
          click_nxt = 1'b1;
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG) || (state_nxt == PRESSED2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      auto_repeat  <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      click        <= click_nxt;
      double_click <= dbl_nxt;
      long_press   <= long_nxt;
      auto_repeat  <= rpt_nxt;
      held         <= held_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed-vector bench for button_event_classifier with LONG=4, REPEAT=2, DCLICK=3.
module tb_button_event_classifier;

  logic clk = 1'b0;
  logic rst, tick, btn_down, btn_up;
  logic click, double_click, long_press, auto_repeat, held;
  logic [4:0] outs;

  always #5 clk = ~clk;

  button_event_classifier #(
    .CNT_W(8), .LONG_TICKS(4), .REPEAT_TICKS(2), .DCLICK_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_down(btn_down), .btn_up(btn_up),
    .click(click), .double_click(double_click), .long_press(long_press),
    .auto_repeat(auto_repeat), .held(held)
  );

  // {click, double_click, long_press, auto_repeat, held}
  assign outs = {click, double_click, long_press, auto_repeat, held};

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] H  = 5'b00001;
  localparam logic [4:0] CK = 5'b10000;
  localparam logic [4:0] DC = 5'b01000;
  localparam logic [4:0] LP = 5'b00101;
  localparam logic [4:0] RP = 5'b00011;
  localparam logic [4:0] CL = 5'b10101;

  int    n_vec = 0;
  int    n_bad = 0;
  int    cnum  = 0;
  string scen;

  task automatic check_vec(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (click,dbl,long,rpt,held)", tag, obs, exp);
    end
  endtask

  // Check the outputs of cycle cnum, then drive that cycle's inputs.
  task automatic cyc(input logic r, input logic d, input logic u, input logic t,
                     input logic [4:0] exp);
    @(posedge clk); #1;
    check_vec($sformatf("%s c%0d", scen, cnum), outs, exp);
    rst = r; btn_down = d; btn_up = u; tick = t;
    cnum++;
  endtask

  task automatic start(input string name);
    scen = name;
    @(posedge clk); #1;
    rst = 1'b1; btn_down = 1'b0; btn_up = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    check_vec({name, " reset"}, outs, Z);
    rst = 1'b0;
    cnum = 0;
  endtask

  initial begin
    rst = 1'b1; btn_down = 1'b0; btn_up = 1'b0; tick = 1'b1;

    start("single");
    cyc(0,1,0,1,Z); cyc(0,0,0,1,H); cyc(0,0,1,1,H); cyc(0,0,0,1,Z);
    cyc(0,0,0,1,Z); cyc(0,0,0,1,Z); cyc(0,0,0,1,CK); cyc(0,0,0,1,Z);

    start("double");
    cyc(0,1,0,1,Z); cyc(0,0,0,1,H); cyc(0,0,1,1,H); cyc(0,0,0,1,Z);
    cyc(0,1,0,1,Z); cyc(0,0,1,1,H); cyc(0,0,0,1,DC); cyc(0,0,0,1,Z);
    cyc(0,0,0,1,Z); cyc(0,0,0,1,Z);

    start("long");
    cyc(0,1,0,1,Z);
    for (int i = 1; i <= 4; i++) cyc(0,0,0,1,H);
    cyc(0,0,0,1,LP); cyc(0,0,0,1,H); cyc(0,0,0,1,RP); cyc(0,0,0,1,H);
    cyc(0,0,0,1,RP); cyc(0,0,0,1,H); cyc(0,0,0,1,RP);
    cyc(0,0,1,1,H); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z);

    start("slowtick");
    for (int c = 0; c <= 18; c++) begin
      logic [4:0] e;
      e = (c == 0 || c >= 18) ? Z : (c == 16) ? LP : H;
      cyc(0, c == 0, c == 17, (c % 4) == 3, e);
    end

    start("dbl_long");
    cyc(0,1,0,1,Z); cyc(0,0,0,1,H); cyc(0,0,1,1,H); cyc(0,0,0,1,Z);
    cyc(0,1,0,1,Z); cyc(0,0,0,1,H); cyc(0,0,0,1,H); cyc(0,0,0,1,H);
    cyc(0,0,0,1,H); cyc(0,0,0,1,CL); cyc(0,0,0,1,H); cyc(0,0,0,1,RP);
    cyc(0,0,0,1,H); cyc(0,0,1,1,RP); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z);

    start("midrst");
    cyc(0,1,0,1,Z);
    for (int i = 1; i <= 4; i++) cyc(0,0,0,1,H);
    cyc(0,0,0,1,LP); cyc(1,0,0,1,H); cyc(0,0,0,1,Z);
    cyc(0,1,0,1,Z); cyc(0,0,0,1,H); cyc(0,0,1,1,H); cyc(0,0,0,1,Z);
    cyc(1,0,0,1,Z); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z);
    cyc(0,0,0,1,Z);

    start("ignored");
    cyc(0,1,1,1,Z); cyc(0,1,0,1,Z); cyc(0,1,0,1,H); cyc(0,1,1,1,H);
    cyc(0,0,1,1,H); cyc(0,0,1,1,Z); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z);
    cyc(0,0,0,1,CK); cyc(0,0,0,1,Z);

    start("up_vs_expire");
    cyc(0,1,0,1,Z); cyc(0,0,0,1,H); cyc(0,0,0,1,H); cyc(0,0,0,1,H);
    cyc(0,0,1,1,H); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z); cyc(0,0,0,1,Z);
    cyc(0,0,0,1,CK); cyc(0,0,0,1,Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
